// File: rtl/sc_hit_scorer.sv
// sc_hit_scorer
//   Grades serialized hit/miss events against the song clock and keeps
//   combo, multiplier and a saturating score for the AV display.
//   Events move through two pipeline stages: S1 holds |dt|, S2 holds the grade.
//   An output register then pulses grade_valid_o and updates the score
//   two cycles after the accept edge. The block takes one event per cycle.
//
// Ports
//   clk_i          system clock
//   reset_i        synchronous active-high reset
//   pause_i        blocks new accepts; events already in the pipeline still finish
//   song_time_i    current song time (wraps mod 2^16)
//   hit_valid_i    serializer presents an event
//   hit_ready_o    event accepted this cycle when high together with hit_valid_i
//   hit_fret_i     fret/lane index
//   hit_time_i     note time of the matched note
//   hit_miss_i     note expired unplayed (forced MISS)
//   grade_valid_o  one-cycle pulse: grade_o/fret_out_o/dt_out_o valid
//   grade_o        3=PERFECT 2=GOOD 1=OK 0=MISS
//   fret_out_o     fret of the graded event
//   dt_out_o       |dt| of the graded event (0 for forced misses)
//   score_o        accumulated score, saturating
//   combo_o        consecutive non-MISS count, saturating at 1023
//   multiplier_o   min(4, 1 + combo/10)
//
// Optional feature (macro SC_STREAK_STATS_EN):
//   max_combo_o    highest combo since reset
//   perfect_cnt_o  saturating count of PERFECT grades
module sc_hit_scorer #(
    parameter int          SCORE_W     = 24,
    parameter logic [15:0] PERFECT_WIN = 16'd2,
    parameter logic [15:0] GOOD_WIN    = 16'd5,
    parameter logic [15:0] OK_WIN      = 16'd10,
    parameter int          PTS_PERFECT = 100,
    parameter int          PTS_GOOD    = 50,
    parameter int          PTS_OK      = 25
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               pause_i,
    input  logic [15:0]        song_time_i,
    input  logic               hit_valid_i,
    output logic               hit_ready_o,
    input  logic [5:0]         hit_fret_i,
    input  logic [15:0]        hit_time_i,
    input  logic               hit_miss_i,
    output logic               grade_valid_o,
    output logic [1:0]         grade_o,
    output logic [5:0]         fret_out_o,
    output logic [15:0]        dt_out_o,
    output logic [SCORE_W-1:0] score_o,
    output logic [9:0]         combo_o,
    output logic [2:0]         multiplier_o
`ifdef SC_STREAK_STATS_EN
    ,
    output logic [9:0]         max_combo_o,
    output logic [15:0]        perfect_cnt_o
`endif
);

    logic               accept;
    logic [15:0]        dt_raw;
    logic [15:0]        dt_abs;

    logic               s1_valid_q;
    logic [5:0]         s1_fret_q;
    logic               s1_miss_q;
    logic [15:0]        s1_adt_q;

    logic [1:0]         s2_grade_d;
    logic               s2_valid_q;
    logic [1:0]         s2_grade_q;
    logic [5:0]         s2_fret_q;
    logic [15:0]        s2_adt_q;

    logic               grade_valid_q;
    logic [1:0]         grade_q;
    logic [5:0]         fret_q;
    logic [15:0]        dt_q;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [9:0]         combo_q, combo_d;
    logic [2:0]         mult_q, mult_d;
    logic [9:0]         base_pts;
    logic [9:0]         pts;
    logic [SCORE_W:0]   score_sum;

    assign hit_ready_o = ~pause_i & ~reset_i;
    assign accept      = hit_valid_i & hit_ready_o;

    // Modular difference read as signed; -32768 has no positive twin, so clamp it.
    assign dt_raw = song_time_i - hit_time_i;
    always_comb begin
        dt_abs = dt_raw;
        if (dt_raw[15]) begin
            if (dt_raw == 16'h8000) dt_abs = 16'h7FFF;
            else                    dt_abs = ~dt_raw + 16'd1;
        end
    end

    always_comb begin
        s2_grade_d = 2'd0;
        if (!s1_miss_q) begin
            if      (s1_adt_q <= PERFECT_WIN) s2_grade_d = 2'd3;
            else if (s1_adt_q <= GOOD_WIN)    s2_grade_d = 2'd2;
            else if (s1_adt_q <= OK_WIN)      s2_grade_d = 2'd1;
        end
    end

    always_comb begin
        case (s2_grade_q)
            2'd3:    base_pts = 10'(PTS_PERFECT);
            2'd2:    base_pts = 10'(PTS_GOOD);
            2'd1:    base_pts = 10'(PTS_OK);
            default: base_pts = 10'd0;
        endcase
        // The multiplier in use is the one derived from the combo before this event.
        pts       = base_pts * {7'd0, mult_q};
        score_sum = {1'b0, score_q} + (SCORE_W+1)'(pts);

        score_d = score_q;
        combo_d = combo_q;
        mult_d  = mult_q;
        if (s2_valid_q) begin
            score_d = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
            if (s2_grade_q == 2'd0)     combo_d = 10'd0;
            else if (combo_q != 10'h3FF) combo_d = combo_q + 10'd1;
            if      (combo_d >= 10'd30) mult_d = 3'd4;
            else if (combo_d >= 10'd20) mult_d = 3'd3;
            else if (combo_d >= 10'd10) mult_d = 3'd2;
            else                        mult_d = 3'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s1_valid_q    <= 1'b0;
            s1_fret_q     <= '0;
            s1_miss_q     <= 1'b0;
            s1_adt_q      <= '0;
            s2_valid_q    <= 1'b0;
            s2_grade_q    <= '0;
            s2_fret_q     <= '0;
            s2_adt_q      <= '0;
            grade_valid_q <= 1'b0;
            grade_q       <= '0;
            fret_q        <= '0;
            dt_q          <= '0;
            score_q       <= '0;
            combo_q       <= '0;
            mult_q        <= 3'd1;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_fret_q <= hit_fret_i;
                s1_miss_q <= hit_miss_i;
                s1_adt_q  <= hit_miss_i ? 16'd0 : dt_abs;
            end
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_grade_q <= s2_grade_d;
                s2_fret_q  <= s1_fret_q;
                s2_adt_q   <= s1_adt_q;
            end
            grade_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                grade_q <= s2_grade_q;
                fret_q  <= s2_fret_q;
                dt_q    <= s2_adt_q;
            end
            score_q <= score_d;
            combo_q <= combo_d;
            mult_q  <= mult_d;
        end
    end

    assign grade_valid_o = grade_valid_q;
    assign grade_o       = grade_q;
    assign fret_out_o    = fret_q;
    assign dt_out_o      = dt_q;
    assign score_o       = score_q;
    assign combo_o       = combo_q;
    assign multiplier_o  = mult_q;

`ifdef SC_STREAK_STATS_EN
    logic [9:0]  max_combo_q;
    logic [15:0] perfect_cnt_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            max_combo_q   <= '0;
            perfect_cnt_q <= '0;
        end else begin
            if (combo_d > max_combo_q) max_combo_q <= combo_d;
            if (s2_valid_q && s2_grade_q == 2'd3 && perfect_cnt_q != 16'hFFFF)
                perfect_cnt_q <= perfect_cnt_q + 16'd1;
        end
    end

    assign max_combo_o   = max_combo_q;
    assign perfect_cnt_o = perfect_cnt_q;
`endif

endmodule

// File: tb/tb_sc_hit_scorer.sv
module tb_sc_hit_scorer;

    localparam longint SCORE_MAX = (64'd1 << 24) - 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pause = 1'b0;
    logic [15:0] song_time = '0;
    logic        hit_valid = 1'b0;
    logic        hit_ready;
    logic [5:0]  hit_fret = '0;
    logic [15:0] hit_time = '0;
    logic        hit_miss = 1'b0;
    logic        grade_valid;
    logic [1:0]  grade;
    logic [5:0]  fret_out;
    logic [15:0] dt_out;
    logic [23:0] score;
    logic [9:0]  combo;
    logic [2:0]  multiplier;
`ifdef SC_STREAK_STATS_EN
    logic [9:0]  max_combo;
    logic [15:0] perfect_cnt;
`endif

    sc_hit_scorer dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .pause_i      (pause),
        .song_time_i  (song_time),
        .hit_valid_i  (hit_valid),
        .hit_ready_o  (hit_ready),
        .hit_fret_i   (hit_fret),
        .hit_time_i   (hit_time),
        .hit_miss_i   (hit_miss),
        .grade_valid_o(grade_valid),
        .grade_o      (grade),
        .fret_out_o   (fret_out),
        .dt_out_o     (dt_out),
        .score_o      (score),
        .combo_o      (combo),
        .multiplier_o (multiplier)
`ifdef SC_STREAK_STATS_EN
        ,
        .max_combo_o  (max_combo),
        .perfect_cnt_o(perfect_cnt)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int fret;
        bit miss;
        int adt;
        int due;
    } ev_t;

    ev_t    q[$];
    int     cyc = 0;
    bit     chk_en = 0;
    bit     e_gv;
    int     e_grade, e_fret, e_dt;
    longint m_score;
    int     m_combo, m_mult, m_maxc, m_perf;

    function automatic int abs_dt(input int st, input int ht);
        int d;
        d = (st - ht) & 16'hFFFF;
        if (d >= 32768) d = d - 65536;
        if (d < 0) d = -d;
        if (d > 32767) d = 32767;
        return d;
    endfunction

    function automatic int grade_of(input bit miss, input int adt);
        if (miss)     return 0;
        if (adt <= 2)  return 3;
        if (adt <= 5)  return 2;
        if (adt <= 10) return 1;
        return 0;
    endfunction

    always @(posedge clk) begin
        ev_t e, n;
        int  pts;
        cyc++;
        e_gv = 0;
        if (reset) begin
            q.delete();
            m_score = 0; m_combo = 0; m_mult = 1; m_maxc = 0; m_perf = 0;
        end else begin
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                e_gv    = 1;
                e_grade = grade_of(e.miss, e.adt);
                e_fret  = e.fret;
                e_dt    = e.adt;
                pts = (e_grade == 3) ? 100 : (e_grade == 2) ? 50 : (e_grade == 1) ? 25 : 0;
                m_score = m_score + pts * m_mult;
                if (m_score > SCORE_MAX) m_score = SCORE_MAX;
                if (e_grade == 0) m_combo = 0;
                else if (m_combo < 1023) m_combo++;
                m_mult = (1 + m_combo / 10 > 4) ? 4 : 1 + m_combo / 10;
                if (m_combo > m_maxc) m_maxc = m_combo;
                if (e_grade == 3 && m_perf < 65535) m_perf++;
            end
            if (hit_valid && !pause) begin
                n.fret = int'(hit_fret);
                n.miss = hit_miss;
                n.adt  = hit_miss ? 0 : abs_dt(int'(song_time), int'(hit_time));
                n.due  = cyc + 2;
                q.push_back(n);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("hit_ready", 32'(hit_ready), 32'(!pause && !reset));
            check("grade_valid", 32'(grade_valid), 32'(e_gv));
            if (e_gv) begin
                check("grade", 32'(grade), 32'(e_grade));
                check("fret_out", 32'(fret_out), 32'(e_fret));
                check("dt_out", 32'(dt_out), 32'(e_dt));
            end
            check("score", 32'(score), 32'(m_score));
            check("combo", 32'(combo), 32'(m_combo));
            check("multiplier", 32'(multiplier), 32'(m_mult));
`ifdef SC_STREAK_STATS_EN
            check("max_combo", 32'(max_combo), 32'(m_maxc));
            check("perfect_cnt", 32'(perfect_cnt), 32'(m_perf));
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input int fret, input int ht, input int st, input bit miss);
        hit_valid = 1'b1;
        hit_fret  = 6'(fret);
        hit_time  = 16'(ht);
        song_time = 16'(st);
        hit_miss  = miss;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        hit_valid = 1'b0;
        hit_miss  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        hit_valid = 1'b0;
        pause     = 1'b0;
        reset     = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk_en = 1;
        reset  = 1'b0;

        // idle after reset
        idle(10);
        check("lit_idle_score", 32'(score), 32'd0);
        check("lit_idle_combo", 32'(combo), 32'd0);
        check("lit_idle_mult", 32'(multiplier), 32'd1);

        // single perfect hit, dt=+1
        drive(7, 100, 101, 0);
        idle(2);
        check("lit_hit_gv", 32'(grade_valid), 32'd1);
        check("lit_hit_grade", 32'(grade), 32'd3);
        check("lit_hit_dt", 32'(dt_out), 32'd1);
        check("lit_hit_score", 32'(score), 32'd100);
        check("lit_hit_combo", 32'(combo), 32'd1);
        idle(2);

        // 12 back-to-back perfect hits from a clean state
        do_reset();
        for (int i = 0; i < 12; i++) drive(i, 1000 + i, 1000 + i, 0);
        idle(4);
        check("lit_b2b_score", 32'(score), 32'd1400);
        check("lit_b2b_combo", 32'(combo), 32'd12);
        check("lit_b2b_mult", 32'(multiplier), 32'd2);

        // forced miss with large combo; dt would otherwise be perfect
        drive(3, 500, 500, 1);
        idle(2);
        check("lit_miss_grade", 32'(grade), 32'd0);
        check("lit_miss_dt", 32'(dt_out), 32'd0);
        check("lit_miss_combo", 32'(combo), 32'd0);
        check("lit_miss_mult", 32'(multiplier), 32'd1);
        check("lit_miss_score", 32'(score), 32'd1400);

        // wrap: 0xFFFE -> 0x0004 is +6 -> OK
        drive(36, 16'hFFFE, 16'h0004, 0);
        idle(2);
        check("lit_wrap_grade", 32'(grade), 32'd1);
        check("lit_wrap_dt", 32'(dt_out), 32'd6);
        check("lit_wrap_score", 32'(score), 32'd1425);

        // window boundaries, negative dt, extreme dt
        drive(1, 16'hFFFE, 16'h0001, 0);   // 3   GOOD
        drive(2, 200, 195, 0);             // -5  GOOD
        drive(3, 300, 302, 0);             // 2   PERFECT
        drive(4, 300, 303, 0);             // 3   GOOD
        drive(5, 400, 410, 0);             // 10  OK
        drive(6, 400, 411, 0);             // 11  MISS
        drive(7, 0, 16'h8000, 0);          // -32768 -> 32767 MISS
        drive(8, 16'h8000, 0, 0);          // -32768 -> 32767 MISS
        drive(9, 50, 40, 0);               // -10 OK
        idle(4);

        // pause: in-flight event completes, new ones blocked
        drive(10, 700, 701, 0);
        pause = 1'b1;
        drive(11, 800, 800, 0);
        check("lit_pause_ready", 32'(hit_ready), 32'd0);
        drive(12, 800, 800, 0);
        drive(13, 800, 800, 0);
        idle(3);
        pause = 1'b0;
        idle(2);

        // reset mid-pipeline drops the in-flight event
        drive(14, 900, 900, 0);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(4);
        check("lit_rst_score", 32'(score), 32'd0);

        // long perfect stream: combo and score saturate
        for (int i = 0; i < 42000; i++) drive(i % 37, i, i, 0);
        idle(4);
        check("lit_sat_score", 32'(score), 32'hFFFFFF);
        check("lit_sat_combo", 32'(combo), 32'd1023);
        check("lit_sat_mult", 32'(multiplier), 32'd4);
        drive(0, 5, 5, 0);
        idle(4);
        check("lit_sat_hold", 32'(score), 32'hFFFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
